// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the Moore sequence detector.
// The state-index width follows the pattern length: states S0..S_PAT_LEN.
package seq_det_pkg;

    localparam int PAT_LEN_MAX = 16;

    // Reset / idle state index.
    localparam int S0 = 0;

    function automatic int state_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

    // Bit 'pos' of the pattern counted from the first bit received.
    function automatic logic pat_bit(input logic [PAT_LEN_MAX-1:0] pattern,
                                     input int pat_len, input int pos);
        logic [PAT_LEN_MAX-1:0] sh;
        sh = pattern >> (pat_len - 1 - pos);
        return sh[0];
    endfunction

    // Longest suffix of (first k pattern bits, a), at most pat_len long, that is
    // also a pattern prefix. For k < pat_len and a matching, this is k+1; for
    // k == pat_len it is the overlapping KMP failure rule. Illegal k maps to S0.
    function automatic int kmp_next(input logic [PAT_LEN_MAX-1:0] pattern,
                                    input int pat_len, input int k, input logic a);
        int   best;
        int   idx;
        logic ok;
        logic sb;
        best = S0;
        if (k > pat_len) return S0;
        for (int j = 1; j <= pat_len; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int m = 0; m < j; m++) begin
                    idx = k + 1 - j + m;
                    sb  = (idx == k) ? a : pat_bit(pattern, pat_len, idx);
                    if (sb != pat_bit(pattern, pat_len, m)) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_det_next.sv
// Next-state rule for the detector: a lookup table per input bit, filled at
// elaboration time from the pattern, with the non-overlapping restart folded in.
module seq_det_next
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
    localparam int                STATE_W = state_w(PAT_LEN)
) (
    input  logic [STATE_W-1:0] state,
    input  logic               a,
    input  logic               ovl_mode,
    output logic [STATE_W-1:0] next_state
);

    localparam int                 NUM_IDX = 1 << STATE_W;
    localparam logic [STATE_W-1:0] S_IDLE  = STATE_W'(S0);
    localparam logic [STATE_W-1:0] S_LAST  = STATE_W'(PAT_LEN);

    logic [STATE_W-1:0] nxt_a0 [NUM_IDX];
    logic [STATE_W-1:0] nxt_a1 [NUM_IDX];
    logic [STATE_W-1:0] sel_state;

    // Every encoding gets an entry; unreachable ones resolve to S0.
    for (genvar k = 0; k < NUM_IDX; k++) begin : g_tbl
        localparam int NX0 = kmp_next(PAT_LEN_MAX'(PATTERN), PAT_LEN, k, 1'b0);
        localparam int NX1 = kmp_next(PAT_LEN_MAX'(PATTERN), PAT_LEN, k, 1'b1);
        assign nxt_a0[k] = STATE_W'(NX0);
        assign nxt_a1[k] = STATE_W'(NX1);
    end

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to remember the old value.
    always_comb begin
        sel_state  = state;
        // Non-overlapping: after a full match the stream restarts from scratch.
        if (state == S_LAST && !ovl_mode) sel_state = S_IDLE;
        next_state = a ? nxt_a1[sel_state] : nxt_a0[sel_state];
    end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with overlapping/non-overlapping modes.
// Define SEQDET_MATCH_CNT_EN to build the saturating match counter.
module moore_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             en,
    input  logic             ovl_mode,
    output logic             d,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int                 STATE_W = state_w(PAT_LEN);
    localparam logic [STATE_W-1:0] S_IDLE  = STATE_W'(S0);
    localparam logic [STATE_W-1:0] S_LAST  = STATE_W'(PAT_LEN);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [STATE_W-1:0] next_state;
    logic               state_legal;

    seq_det_next #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_next (
        .state      (state_q),
        .a          (a),
        .ovl_mode   (ovl_mode),
        .next_state (next_state)
    );

    always_comb begin
        state_legal = (state_q <= S_LAST);
        state_d     = state_q;
        // A corrupted encoding recovers to S0 even while sampling is paused.
        if (!state_legal)  state_d = S_IDLE;
        else if (en)       state_d = next_state;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Moore output: decoded from the state register alone.
    assign d = (state_q == S_LAST);

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hit;

    always_comb begin
        hit   = en && state_legal && (next_state == S_LAST);
        cnt_d = cnt_q;
        if (hit && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Scoreboard bench: three detector instances (1010/8-bit count, 1101, 1010/2-bit
// count) driven in lockstep and compared against a history-based reference model.
module tb_moore_seq_detector;

`ifdef SEQDET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       a = 1'b0;
    logic       en = 1'b0;
    logic       ovl_mode = 1'b0;
    logic       d_a, d_b, d_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    always #5 clk = ~clk;

    moore_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(8)) u_dut_a (
        .clk(clk), .reset(reset), .a(a), .en(en), .ovl_mode(ovl_mode),
        .d(d_a), .match_cnt(cnt_a));
    moore_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(8)) u_dut_b (
        .clk(clk), .reset(reset), .a(a), .en(en), .ovl_mode(ovl_mode),
        .d(d_b), .match_cnt(cnt_b));
    moore_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(2)) u_dut_c (
        .clk(clk), .reset(reset), .a(a), .en(en), .ovl_mode(ovl_mode),
        .d(d_c), .match_cnt(cnt_c));

    typedef struct packed {
        logic [2:0]  d;
        logic [31:0] c0;
        logic [31:0] c1;
        logic [31:0] c2;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] trace_a = '0;
    logic [31:0] trace_b = '0;

    // Reference model: raw bit history since the last reset (or since a
    // non-overlapping match); the state is its longest suffix matching a prefix.
    logic [3:0]  m_pat  [N] = '{4'b1010, 4'b1101, 4'b1010};
    int          m_cmax [N] = '{255, 255, 3};
    logic [31:0] m_hist [N] = '{0, 0, 0};
    int          m_hlen [N] = '{0, 0, 0};
    bit          m_match[N] = '{0, 0, 0};
    int          m_cnt  [N] = '{0, 0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int longest(input logic [3:0] p, input logic [31:0] h, input int hl);
        logic [31:0] hs;
        logic [3:0]  ps;
        bit          ok;
        for (int j = 4; j >= 1; j--) begin
            if (j <= hl) begin
                ok = 1'b1;
                for (int m = 0; m < j; m++) begin
                    hs = h >> (j - 1 - m);
                    ps = p >> (3 - m);
                    if (hs[0] != ps[0]) ok = 1'b0;
                end
                if (ok) return j;
            end
        end
        return 0;
    endfunction

    task automatic model_apply(input bit rst, input bit e, input bit bit_a, input bit ovl);
        for (int i = 0; i < N; i++) begin
            if (!rst) begin
                m_hist[i] = '0; m_hlen[i] = 0; m_match[i] = 1'b0; m_cnt[i] = 0;
            end else if (e) begin
                if (m_match[i] && !ovl) m_hlen[i] = 0;
                m_hist[i] = {m_hist[i][30:0], bit_a};
                if (m_hlen[i] < 32) m_hlen[i]++;
                m_match[i] = (longest(m_pat[i], m_hist[i], m_hlen[i]) == 4);
                if (m_match[i] && CNT_EN && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
            end
        end
    endtask

    task automatic drive(input bit rst, input bit e, input bit bit_a, input bit ovl);
        exp_t ex;
        @(negedge clk);
        reset = rst; en = e; a = bit_a; ovl_mode = ovl;
        model_apply(rst, e, bit_a, ovl);
        ex.d  = {m_match[2], m_match[1], m_match[0]};
        ex.c0 = m_cnt[0]; ex.c1 = m_cnt[1]; ex.c2 = m_cnt[2];
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        ex = sb_q.pop_front();
        check("d_a", {31'd0, d_a}, {31'd0, ex.d[0]});
        check("d_b", {31'd0, d_b}, {31'd0, ex.d[1]});
        check("d_c", {31'd0, d_c}, {31'd0, ex.d[2]});
        check("cnt_a", 32'(cnt_a), ex.c0);
        check("cnt_b", 32'(cnt_b), ex.c1);
        check("cnt_c", 32'(cnt_c), ex.c2);
        trace_a = {trace_a[30:0], d_a};
        trace_b = {trace_b[30:0], d_b};
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        trace_a = '0;
        trace_b = '0;
    endtask

    task automatic run_stream(input logic [15:0] bits, input int n, input bit ovl);
        logic [15:0] t;
        for (int i = n - 1; i >= 0; i--) begin
            t = bits >> i;
            drive(1'b1, 1'b1, t[0], ovl);
        end
    endtask

    initial begin
        do_reset();
        check("rst_d_a", {31'd0, d_a}, 32'd0);
        check("rst_cnt_a", 32'(cnt_a), 32'd0);

        // 1010 stream, non-overlapping: matches after bits 4 and 8.
        do_reset();
        run_stream(16'b1010_1010, 8, 1'b0);
        check("nonovl_1010_trace", trace_a[7:0], 32'b0001_0001);
        check("nonovl_1010_cnt", 32'(cnt_a), CNT_EN ? 32'd2 : 32'd0);

        // Same stream, overlapping: matches after bits 4, 6 and 8.
        do_reset();
        run_stream(16'b1010_1010, 8, 1'b1);
        check("ovl_1010_trace", trace_a[7:0], 32'b0001_0101);
        check("ovl_1010_cnt", 32'(cnt_a), CNT_EN ? 32'd3 : 32'd0);

        // 1101 with stream 1101101 in both modes.
        do_reset();
        run_stream(16'b110_1101, 7, 1'b1);
        check("ovl_1101_trace", trace_b[6:0], 32'b000_1001);
        do_reset();
        run_stream(16'b110_1101, 7, 1'b0);
        check("nonovl_1101_trace", trace_b[6:0], 32'b000_1000);

        // Reset mid-pattern discards the partial match.
        do_reset();
        run_stream(16'b101, 3, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("midrst_d", {31'd0, d_a}, 32'd0);
        check("midrst_cnt", 32'(cnt_a), 32'd0);

        // en=0 holds the partial match.
        do_reset();
        run_stream(16'b10, 2, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0);
        run_stream(16'b10, 2, 1'b0);
        check("hold_en_d", {31'd0, d_a}, 32'd1);

        // Mode change mid-pattern keeps the partial match.
        do_reset();
        run_stream(16'b10, 2, 1'b0);
        run_stream(16'b10, 2, 1'b1);
        check("mode_switch_d", {31'd0, d_a}, 32'd1);

        // Five overlapping matches saturate the 2-bit counter.
        do_reset();
        run_stream(16'b1010_1010_1010, 12, 1'b1);
        check("sat_cnt_c", 32'(cnt_c), CNT_EN ? 32'd3 : 32'd0);
        check("nosat_cnt_a", 32'(cnt_a), CNT_EN ? 32'd5 : 32'd0);

        // Random traffic with occasional resets, pauses and mode flips.
        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/moore_seq_detector.md
MOORE_SEQ_DETECTOR -- requirements
Module: moore_seq_detector

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter PATTERN, default 4'b1010 (width PAT_LEN): the target sequence; PATTERN[PAT_LEN-1] is the first bit received.
REQ-003 The block SHALL have parameter CNT_W, default 8: match counter width, legal range 1..32.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising clk edge.
REQ-006 The block SHALL have port a, input, 1 bit: the serial data bit.
REQ-007 The block SHALL have port en, input, 1 bit: sample enable; a is consumed only when en=1.
REQ-008 The block SHALL have port ovl_mode, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-009 The block SHALL have port d, output, 1 bit: Moore match flag.
REQ-010 The block SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.

Function
REQ-011 The FSM SHALL have states S0..S_PAT_LEN, where Sk means the last k consumed bits equal the first k pattern bits.
REQ-012 From Sk (k<PAT_LEN) with en=1, the FSM SHALL go to Sk+1 when a = PATTERN[PAT_LEN-1-k]; otherwise to Sj, where j is the longest proper suffix of (matched prefix, a) that is also a pattern prefix (KMP failure rule), j possibly 0.
REQ-013 From S_PAT_LEN with ovl_mode=1, the FSM SHALL apply the REQ-012 failure rule to the full pattern followed by a.
REQ-014 From S_PAT_LEN with ovl_mode=0, the FSM SHALL go to S1 if a = PATTERN[PAT_LEN-1], else to S0.
REQ-015 With en=0, the FSM SHALL hold its state, d SHALL hold, and match_cnt SHALL hold.
REQ-016 d SHALL be 1 exactly while the state is S_PAT_LEN; it is decoded from the state register only, with no combinational path from a, en or ovl_mode.
REQ-017 d SHALL rise on the clk edge that consumes the last pattern bit (zero cycles of extra latency beyond the state register).
REQ-018 match_cnt SHALL increment by 1 on each transition into S_PAT_LEN and SHALL saturate at 2^CNT_W-1.
REQ-019 ovl_mode SHALL be sampled every cycle and SHALL affect only transitions out of S_PAT_LEN; changing it mid-pattern SHALL not alter the partial match.
REQ-020 Unreachable state encodings SHALL transition to S0 with d=0.

Reset
REQ-021 When reset=0 at a clk edge, state SHALL become S0, d SHALL be 0 and match_cnt SHALL be 0, regardless of en and a.
REQ-022 Reset asserted mid-pattern SHALL discard the partial match; the first bit consumed after release is treated as the first bit of a new stream.

Configuration
REQ-023 With macro SEQDET_MATCH_CNT_EN defined, the counter of REQ-018 SHALL be compiled in; without it, match_cnt SHALL be tied to 0, no counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-024 Package seq_det_pkg SHALL hold the state-index width constant (clog2(PAT_LEN+1)) and the reset-state constant S0.
REQ-025 The next-state rule SHALL be one combinational sub-module, seq_det_next, parametrised by PAT_LEN and PATTERN, with inputs state, a and ovl_mode and output next_state; the failure table is computed at elaboration time.

Verification
REQ-026 With PATTERN=1010, ovl_mode=0, en=1 and stream 1,0,1,0,1,0,1,0, d SHALL be 1 after bits 4 and 8 only, and match_cnt SHALL equal 2.
REQ-027 With the same stream and ovl_mode=1, d SHALL be 1 after bits 4, 6 and 8, and match_cnt SHALL equal 3.
REQ-028 With PATTERN=1101 and stream 1,1,0,1,1,0,1, ovl_mode=1 SHALL give matches after bits 4 and 7; ovl_mode=0 SHALL give a match after bit 4 only.
REQ-029 With PATTERN=1010 and stream 1,0,1, then reset=0 for one cycle, then 0, d SHALL stay 0 and match_cnt SHALL stay 0.
REQ-030 With PATTERN=1010, stream 1,0, then en=0 with a=1 for 3 cycles, then 1,0 with en=1, d SHALL be 1 after the final bit.
REQ-031 With CNT_W=2, ovl_mode=1 and PATTERN=1010, five matches SHALL leave match_cnt=3; without SEQDET_MATCH_CNT_EN, match_cnt SHALL read 0 throughout.
